// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction ROM port, redirect input and decode-side handshake.
// The master modport is the fetch unit; the slave modport is its environment (ROM, decode, branch).
interface instr_fetch_unit_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            fetch_en;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [31:0]     redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [31:0]     instr_pc;
    logic [CntW-1:0] q_count;

    modport master (
        input  fetch_en, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        output imem_addr, instr_valid, instr, instr_pc, q_count
    );

    modport slave (
        output fetch_en, imem_rdata, redirect_valid, redirect_pc, instr_ready,
        input  imem_addr, instr_valid, instr, instr_pc, q_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the ROM address from fetch_pc, buffers {pc, instr} pairs
// in a DEPTH-entry prefetch queue popped by decode; a redirect flushes and restarts fetch.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [63:0]     mem_q [DEPTH];
    logic [63:0]     mem_d [DEPTH];

    logic not_empty;
    logic push;
    logic pop;

    assign not_empty = (count_q != '0);
    assign pop  = not_empty & bus.instr_ready & ~bus.redirect_valid;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push = bus.fetch_en & ~bus.redirect_valid & ((count_q < CntW'(DEPTH)) | pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {fetch_pc_q, bus.imem_rdata};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                fetch_pc_d      = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = not_empty;
    assign bus.q_count     = count_q;
    assign bus.instr       = not_empty ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign bus.instr_pc    = not_empty ? mem_q[rd_ptr_q][63:32] : 32'h0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run against a
// queue-based reference model of the fetch/prefetch behaviour.
module tb_instr_fetch_unit;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] salt = 32'h0;
    int total = 0;
    int bad   = 0;

    instr_fetch_unit_if #(.DEPTH(DEPTH)) bus ();

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] addr);
        return (addr >> 2) ^ salt;
    endfunction

    assign bus.imem_rdata = rom(bus.imem_addr);

    // Reference model: fetch PC plus a FIFO of {pc, instr} entries.
    logic [31:0] pc_m;
    logic [63:0] q_m[$];

    function automatic void model_tick(input logic rstn, input logic fe, input logic rdy,
                                       input logic rv, input logic [31:0] rpc);
        bit do_pop, do_push;
        if (!rstn) begin
            pc_m = RESET_PC;
            q_m.delete();
        end else if (rv) begin
            q_m.delete();
            pc_m = rpc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (q_m.size() != 0) && rdy;
            do_push = fe && ((q_m.size() < DEPTH) || do_pop);
            if (do_pop) void'(q_m.pop_front());
            if (do_push) begin
                q_m.push_back({pc_m, rom(pc_m)});
                pc_m = pc_m + 32'd4;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rstn, input logic fe, input logic rdy,
                         input logic rv, input logic [31:0] rpc);
        rst_n              = rstn;
        bus.fetch_en       = fe;
        bus.instr_ready    = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        step();
        total++; if (bus.q_count !== 3'd0) begin
            bad++; $display("FAIL reset_count got=%0d exp=0", bus.q_count); end
        total++; if (bus.instr_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b exp=0", bus.instr_valid); end
        total++; if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            bad++; $display("FAIL reset_head got=%h/%h exp=0/0", bus.instr_pc, bus.instr); end
        total++; if (bus.imem_addr !== RESET_PC) begin
            bad++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i) ||
                bus.instr !== 32'(i) || bus.q_count !== 3'd1) begin
                bad++;
                $display("FAIL stream i=%0d got v=%b pc=%h ins=%h cnt=%0d exp v=1 pc=%h ins=%h cnt=1",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, bus.q_count, 4 * i, i);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) step();
        total++; if (bus.q_count !== 3'd4) begin
            bad++; $display("FAIL bp_count got=%0d exp=4", bus.q_count); end
        total++; if (bus.imem_addr !== 32'h10) begin
            bad++; $display("FAIL bp_addr got=%h exp=00000010", bus.imem_addr); end
        total++; if (bus.instr_pc !== 32'h0 || bus.instr !== 32'h0) begin
            bad++; $display("FAIL bp_head got=%h/%h exp=0/0", bus.instr_pc, bus.instr); end
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4 * i) || bus.instr !== 32'(i)) begin
                bad++;
                $display("FAIL bp_drain i=%0d got v=%b pc=%h ins=%h exp pc=%h ins=%h",
                         i, bus.instr_valid, bus.instr_pc, bus.instr, 4 * i, i);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        total++; if (bus.q_count !== 3'd4) begin
            bad++; $display("FAIL redir_prefill got=%0d exp=4", bus.q_count); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h23);
        step();
        bus.redirect_valid = 1'b0;
        total++; if (bus.q_count !== 3'd0 || bus.instr_valid !== 1'b0) begin
            bad++; $display("FAIL redir_flush got cnt=%0d v=%b exp 0/0", bus.q_count, bus.instr_valid); end
        total++; if (bus.imem_addr !== 32'h20) begin
            bad++; $display("FAIL redir_addr got=%h exp=00000020", bus.imem_addr); end
        step();
        total++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h20 || bus.instr !== 32'h8) begin
            bad++; $display("FAIL redir_first got v=%b pc=%h ins=%h exp v=1 pc=00000020 ins=00000008",
                            bus.instr_valid, bus.instr_pc, bus.instr); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE);
        step();
        bus.redirect_valid = 1'b0;
        total++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", bus.imem_addr); end
        step();
        total++; if (bus.instr_pc !== 32'hFFFF_FFFC || bus.instr !== 32'h3FFF_FFFF) begin
            bad++; $display("FAIL wrap_entry got=%h/%h exp=fffffffc/3fffffff", bus.instr_pc, bus.instr); end
        total++; if (bus.imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_addr1 got=%h exp=00000000", bus.imem_addr); end
        step();
        total++; if (bus.instr_pc !== 32'h0) begin
            bad++; $display("FAIL wrap_next got=%h exp=00000000", bus.instr_pc); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++; if (bus.q_count !== 3'd3) begin
            bad++; $display("FAIL midrst_fill got=%0d exp=3", bus.q_count); end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        total++;
        if (bus.q_count !== 3'd0 || bus.instr !== 32'h0 || bus.instr_valid !== 1'b0 ||
            bus.imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL midrst got cnt=%0d ins=%h v=%b addr=%h exp 0/0/0/%h",
                     bus.q_count, bus.instr, bus.instr_valid, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic        rstn, fe, rdy, rv;
        logic [31:0] rpc;
        logic [63:0] head;
        logic [31:0] last_pc;
        bit          have_last;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        salt = 32'h1234_5678;
        model_tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        have_last = 1'b0;
        last_pc   = '0;
        rst_n     = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            head = (q_m.size() != 0) ? q_m[0] : 64'h0;
            total++; if (bus.imem_addr !== pc_m) begin
                bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, bus.imem_addr, pc_m); end
            total++; if (bus.q_count !== 3'(q_m.size()) || bus.instr_valid !== (q_m.size() != 0)) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%b exp=%0d", c, bus.q_count,
                                bus.instr_valid, q_m.size()); end
            total++; if ({bus.instr_pc, bus.instr} !== head) begin
                bad++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h", c, bus.instr_pc,
                                bus.instr, head); end

            rstn = ($urandom_range(999) != 0);
            fe   = ($urandom_range(3) != 0);
            rdy  = ($urandom_range(2) != 0);
            rv   = ($urandom_range(24) == 0);
            rpc  = $urandom;
            drive(rstn, fe, rdy, rv, rpc);

            if (!rstn || rv) begin
                have_last = 1'b0;
            end else if (bus.instr_valid === 1'b1 && rdy) begin
                if (have_last) begin
                    total++; if (bus.instr_pc !== last_pc + 32'd4) begin
                        bad++; $display("FAIL rnd_contig cyc=%0d got=%h exp=%h", c, bus.instr_pc,
                                        last_pc + 32'd4); end
                end
                last_pc   = bus.instr_pc;
                have_last = 1'b1;
            end
            model_tick(rstn, fe, rdy, rv, rpc);
            step();
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
